// File: rtl/fan_tach_meter.sv
// Fan tachometer meter: synchronises tach_in, counts rising edges per gate window,
// measures edge-to-edge period in clock cycles and flags a stalled fan.
module fan_tach_meter #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int STALL_CYCLES  = 500,
  parameter int CNT_W         = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tach_in,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             stall,
  output logic             dbg_armed
);

  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_ONE    = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_CYCLES - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  // Valid/ready note: this block has no backpressure; count_valid and
  // period_valid are single-cycle qualifiers for edge_count and period,
  // which hold their values between pulses.

  logic             r_s1;
  logic             r_s2;
  logic             r_d;
  logic [WIN_W-1:0] r_win;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_per;
  state_t           r_state;
  logic [CNT_W-1:0] r_edge_count;
  logic             r_count_valid;
  logic [CNT_W-1:0] r_period;
  logic             r_period_valid;
  logic             r_stall;

  logic             w_rise;
  logic             w_win_last;
  logic [CNT_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_per_inc;
  logic             w_stall_hit;
  state_t           w_state_next;
  logic             w_period_load;
  logic             w_stall_set;
  logic             w_stall_clr;

  assign w_rise      = r_s2 & ~r_d;
  assign w_win_last  = (r_win == WIN_LAST);
  assign w_acc_next  = (w_rise && !(&r_acc)) ? r_acc + CNT_ONE : r_acc;
  assign w_per_inc   = (&r_per) ? r_per : r_per + CNT_ONE;
  // A rise on the same cycle as the stall threshold keeps the fan alive.
  assign w_stall_hit = (r_per == STALL_LAST) && !w_rise;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_period_load = 1'b0;
    w_stall_set   = 1'b0;
    w_stall_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_next = ST_ARMED;
          w_stall_clr  = 1'b1;
        end else if (w_stall_hit) begin
          w_stall_set = 1'b1;
        end
      end
      ST_ARMED: begin
        if (w_rise) begin
          w_period_load = 1'b1;
          w_stall_clr   = 1'b1;
        end else if (w_stall_hit) begin
          w_state_next = ST_IDLE;
          w_stall_set  = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_s1           <= 1'b0;
      r_s2           <= 1'b0;
      r_d            <= 1'b0;
      r_win          <= '0;
      r_acc          <= '0;
      r_per          <= '0;
      r_edge_count   <= '0;
      r_count_valid  <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_stall        <= 1'b0;
    end else begin
      r_s1 <= tach_in;
      r_s2 <= r_s1;
      r_d  <= r_s2;

      // A rise on the terminal window cycle is folded into the closing count.
      r_win         <= w_win_last ? '0 : r_win + WIN_ONE;
      r_acc         <= w_win_last ? '0 : w_acc_next;
      r_count_valid <= w_win_last;
      if (w_win_last) begin
        r_edge_count <= w_acc_next;
      end

      r_per          <= w_rise ? '0 : w_per_inc;
      r_period_valid <= w_period_load;
      if (w_period_load) begin
        r_period <= w_per_inc;
      end else if (w_stall_set) begin
        r_period <= '0;
      end

      if (w_stall_set) begin
        r_stall <= 1'b1;
      end else if (w_stall_clr) begin
        r_stall <= 1'b0;
      end
    end
  end

  assign edge_count   = r_edge_count;
  assign count_valid  = r_count_valid;
  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign stall        = r_stall;
  assign dbg_armed    = (r_state == ST_ARMED);

endmodule

// File: tb/tb_fan_tach_meter.sv
// Bench for fan_tach_meter: two instances (default-like and 4-bit saturating)
// checked every cycle against a timestamp-based model of edges, windows and gaps.
module tb_fan_tach_meter;

  localparam int W_A = 20;
  localparam int S_A = 50;
  localparam int C_A = 16;
  localparam int W_B = 40;
  localparam int S_B = 15;
  localparam int C_B = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tach_a = 1'b0;
  logic tach_b = 1'b0;

  logic [C_A-1:0] ec_a, pr_a;
  logic cv_a, pv_a, st_a, arm_a;
  logic [C_B-1:0] ec_b, pr_b;
  logic cv_b, pv_b, st_b, arm_b;

  fan_tach_meter #(.WINDOW_CYCLES(W_A), .STALL_CYCLES(S_A), .CNT_W(C_A)) u_a (
    .clk_in(clk), .rst(rst), .tach_in(tach_a),
    .edge_count(ec_a), .count_valid(cv_a), .period(pr_a),
    .period_valid(pv_a), .stall(st_a), .dbg_armed(arm_a)
  );

  fan_tach_meter #(.WINDOW_CYCLES(W_B), .STALL_CYCLES(S_B), .CNT_W(C_B)) u_b (
    .clk_in(clk), .rst(rst), .tach_in(tach_b),
    .edge_count(ec_b), .count_valid(cv_b), .period(pr_b),
    .period_valid(pv_b), .stall(st_b), .dbg_armed(arm_b)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: per instance, params and state
  int   m_w[2];
  int   m_s[2];
  int   m_max[2];
  logic [2:0] m_h[2];   // last three tach samples, newest in bit 2
  int   m_n[2];         // cycles since reset release
  int   m_rc[2];        // rises in the open window
  int   m_rlast[2];     // cycle of last rise (or -1 after reset)
  bit   m_arm[2];       // a reference rise exists for a period measurement
  int   e_ec[2];
  int   e_pr[2];
  bit   e_cv[2];
  bit   e_pv[2];
  bit   e_st[2];

  logic [C_A-1:0] exp_q[$];   // expected period values for instance A

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_to(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step(input int i, input bit r, input bit t);
    bit rise;
    if (r) begin
      m_h[i] = 3'b000; m_n[i] = 0; m_rc[i] = 0; m_rlast[i] = -1; m_arm[i] = 0;
      e_ec[i] = 0; e_pr[i] = 0; e_cv[i] = 0; e_pv[i] = 0; e_st[i] = 0;
      if (i == 0) exp_q.delete();
      return;
    end
    // a rise is a high sample two edges back preceded by a low sample
    rise = m_h[i][1] & ~m_h[i][0];
    m_h[i] = {t, m_h[i][2:1]};
    if (rise) m_rc[i]++;
    e_cv[i] = 0;
    if (m_n[i] % m_w[i] == m_w[i] - 1) begin
      e_ec[i] = sat_to(m_rc[i], m_max[i]);
      e_cv[i] = 1;
      m_rc[i] = 0;
    end
    e_pv[i] = 0;
    if (rise) begin
      if (m_arm[i]) begin
        e_pr[i] = sat_to(m_n[i] - m_rlast[i], m_max[i]);
        e_pv[i] = 1;
        if (i == 0) exp_q.push_back(e_pr[i][C_A-1:0]);
      end
      m_arm[i] = 1;
      e_st[i] = 0;
      m_rlast[i] = m_n[i];
    end else if (m_n[i] - m_rlast[i] == m_s[i]) begin
      e_st[i] = 1;
      e_pr[i] = 0;
      m_arm[i] = 0;
    end
    m_n[i]++;
  endtask

  task automatic compare();
    chk("a_edge_count", ec_a, e_ec[0]);
    chk("a_count_valid", cv_a, e_cv[0]);
    chk("a_period", pr_a, e_pr[0]);
    chk("a_period_valid", pv_a, e_pv[0]);
    chk("a_stall", st_a, e_st[0]);
    chk("a_armed", arm_a, m_arm[0]);
    chk("b_edge_count", ec_b, e_ec[1]);
    chk("b_count_valid", cv_b, e_cv[1]);
    chk("b_period", pr_b, e_pr[1]);
    chk("b_period_valid", pv_b, e_pv[1]);
    chk("b_stall", st_b, e_st[1]);
    chk("b_armed", arm_b, m_arm[1]);
    if (pv_a === 1'b1) begin
      chk("a_pv_has_expect", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("a_period_queue", pr_a, exp_q.pop_front());
    end
  endtask

  // driver tasks
  task automatic cycle(input bit r, input bit ta, input bit tb);
    rst = r; tach_a = ta; tach_b = tb;
    @(posedge clk);
    model_step(0, r, ta);
    model_step(1, r, tb);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic square(input int pa, input int pb, input int len);
    for (int k = 0; k < len; k++)
      cycle(1'b0, (pa > 0) && ((k % pa) < pa / 2), (pb > 0) && ((k % pb) < pb / 2));
  endtask

  task automatic drive_edges(input int ga, input int gb, input int len);
    for (int k = 0; k < len; k++)
      cycle(1'b0, (ga > 0) && (k % ga == 0), (gb > 0) && (k % gb == 0));
  endtask

  task automatic random_run(input int len);
    int rem_a, rem_b, g_a, g_b, hi_a, hi_b;
    bit ta, tb;
    rem_a = 0; rem_b = 0; g_a = 2; g_b = 2; hi_a = 1; hi_b = 1;
    for (int k = 0; k < len; k++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset($urandom_range(1, 2));
        rem_a = 0; rem_b = 0;
      end
      if (rem_a == 0) begin
        g_a = $urandom_range(2, 70);
        if (g_a == S_A) g_a++;
        hi_a = $urandom_range(1, g_a - 1);
        rem_a = g_a;
      end
      if (rem_b == 0) begin
        g_b = $urandom_range(2, 22);
        if (g_b == S_B) g_b++;
        hi_b = $urandom_range(1, g_b - 1);
        rem_b = g_b;
      end
      ta = (g_a - rem_a) < hi_a;
      tb = (g_b - rem_b) < hi_b;
      rem_a--; rem_b--;
      cycle(1'b0, ta, tb);
    end
  endtask

  initial begin
    m_w[0] = W_A; m_s[0] = S_A; m_max[0] = (1 << C_A) - 1;
    m_w[1] = W_B; m_s[1] = S_B; m_max[1] = (1 << C_B) - 1;

    // steady square wave on A, every-cycle toggle on B (saturation)
    do_reset(2);
    chk("reset_edge_count", ec_a, 0);
    chk("reset_stall", st_a, 0);
    square(10, 2, 100);
    chk("lit_a_edge_count_2", ec_a, 2);
    chk("lit_a_period_10", pr_a, 10);
    chk("lit_a_no_stall", st_a, 0);
    chk("lit_b_edge_count_sat", ec_b, 15);
    chk("lit_b_period_2", pr_b, 2);

    // no tach after reset
    do_reset(2);
    for (int k = 0; k < 60; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (k == 13) chk("lit_b_stall_not_yet", st_b, 0);
      if (k == 14) chk("lit_b_stall_at_15", st_b, 1);
      if (k == 19) chk("lit_a_empty_window", ec_a, 0);
      if (k == 48) chk("lit_a_stall_not_yet", st_a, 0);
      if (k == 49) chk("lit_a_stall_at_50", st_a, 1);
    end
    chk("lit_a_period_0_stalled", pr_a, 0);

    // stall recovery, gap 12 on A, gap 14 on B
    drive_edges(12, 14, 30);
    drive_edges(0, 0, 5);
    chk("lit_a_period_12", pr_a, 12);
    chk("lit_a_recovered", st_a, 0);
    chk("lit_b_period_14", pr_b, 14);
    drive_edges(0, 0, 20);
    chk("lit_b_stall_gap", st_b, 1);
    chk("lit_b_period_cleared", pr_b, 0);

    // single rise landing on the terminal window cycle
    do_reset(1);
    for (int j = 0; j < 40; j++) begin
      cycle(1'b0, j == 17, 1'b0);
      if (j == 19) begin
        chk("lit_a_terminal_count", ec_a, 1);
        chk("lit_a_terminal_valid", cv_a, 1);
      end
      if (j == 39) chk("lit_a_next_window_0", ec_a, 0);
    end

    // reset in the middle of a window
    do_reset(1);
    square(10, 0, 29);
    cycle(1'b1, 1'b0, 1'b0);
    chk("lit_mid_rst_edge_count", ec_a, 0);
    chk("lit_mid_rst_period", pr_a, 0);
    chk("lit_mid_rst_valids", {cv_a, pv_a, st_a}, 0);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, (k % 10) < 5, 1'b0);
      if (k == 11) chk("lit_first_rise_only_arms", pv_a, 0);
      if (k == 12) chk("lit_post_rst_period", pr_a, 10);
      if (k == 18) chk("lit_no_early_count_valid", cv_a, 0);
      if (k == 19) chk("lit_count_valid_20_after", cv_a, 1);
    end

    random_run(4000);
    drive_edges(0, 0, 60);
    chk("a_exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fan_tach_meter.md
# fan_tach_meter

Measures fan speed from the fan's tachometer output, a slow periodic signal generated off-chip. The block synchronises `tach_in` into the system clock domain and detects rising edges. It reports two measurements: the edge count per fixed gate window, and the period between successive edges in clock cycles. It also flags a stalled fan. It sits beside the fan PWM/drive logic in the fan controller and runs on the same divided system clock.

## Interface
- `WINDOW_CYCLES`, 1000: gate window length in clock cycles; ≥ 2.
- `STALL_CYCLES`, 500: cycles without a rising edge before `stall` asserts; 2 ≤ STALL_CYCLES ≤ 2^CNT_W−1.
- `CNT_W`, 16: width of all counters and measurement outputs.
- `clk_in`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `tach_in`  input  1  raw fan tachometer signal, asynchronous to `clk_in`.
- `edge_count`  output  CNT_W  rising edges seen in the last completed window, saturating.
- `count_valid`  output  1  one-cycle pulse when `edge_count` updates.
- `period`  output  CNT_W  cycles between the last two rising edges, saturating; 0 after stall.
- `period_valid`  output  1  one-cycle pulse when `period` updates.
- `stall`  output  1  no rising edge for STALL_CYCLES cycles.

## Operation
- Synchroniser and edge detect:
  - `tach_in` → `s1` → `s2` (2 flops), then `s2` → `d` (1 flop).
  - Internal `rise` = `s2 & ~d`.
  - No deglitching. A `tach_in` high lasting at least 1 clock sample counts.
- Window counter `win` runs 0..WINDOW_CYCLES−1 and wraps.
  - Accumulator `acc` increments on `rise`, saturating at 2^CNT_W−1.
  - On the cycle where `win == WINDOW_CYCLES−1`: `edge_count <= sat(acc + rise)`, `acc <= 0`, and `count_valid` pulses.
  - A rise on the terminal cycle belongs to the closing window.
- Period counter `per` increments every cycle, saturating at 2^CNT_W−1, and clears to 0 on `rise`.
- `armed` flag, two states:
  - IDLE (`armed = 0`): a `rise` moves to ARMED. `stall <= 0`. `period` is not updated and there is no `period_valid`.
  - ARMED (`armed = 1`): a `rise` sets `period <= sat(per + 1)` and pulses `period_valid`.
  - ARMED → IDLE when `per == STALL_CYCLES−1` with no `rise` in that cycle. At that point `stall <= 1` and `period <= 0`.
  - In IDLE with no edges, `stall` asserts once `per` first reaches STALL_CYCLES−1. It stays high until the next `rise`.
- Reset drives `s1`, `s2`, `d`, `win`, `acc`, `per`, and `armed` to 0, so the block starts in IDLE. All outputs reset to 0.
- Reset mid-window discards the partial window and the partial period. The first measurements after reset follow normal rules.

## Timing
- A `tach_in` rising edge sampled at clock edge k produces `rise` in the cycle after edge k+1. Its effects register at edge k+2.
- `count_valid` asserts for exactly 1 cycle every WINDOW_CYCLES cycles. The first pulse is on the WINDOW_CYCLES-th edge after `rst` deasserts.
- `edge_count`, `period`, and `stall` hold their value between updates.
- `period_valid` and `count_valid` may assert in the same cycle; they are independent.
- Minimum measurable period is 2, since `rise` needs a low sample between highs.
- Period at or above STALL_CYCLES is never reported. Stall wins.
- `rise` and the stall condition in the same cycle: `rise` wins. `per` clears and `stall` does not assert.

## Test plan
Use WINDOW_CYCLES=20, STALL_CYCLES=50, CNT_W=16 unless noted.
1. **Steady square wave.** Reset 2 cycles, then `tach_in` with period 10 (5 high, 5 low) → from the second window onward `edge_count`=2 with `count_valid` every 20 cycles; `period`=10 with `period_valid` every 10 cycles from the second rise; `stall` stays 0.
2. **No tach after reset.** Hold `tach_in`=0 → `stall` rises 50 cycles after reset release; `edge_count`=0 each window; `period`=0 and `period_valid` never pulses.
3. **Stall recovery.** From stall, first rise → `stall`=0, no `period_valid`. Second rise 12 cycles later → `period`=12 with one `period_valid`.
4. **Terminal-cycle edge.** Place a single rise on the `win`=19 cycle → that window's `edge_count`=1, and the next window is 0.
5. **Saturation (CNT_W=4, WINDOW_CYCLES=40, STALL_CYCLES=15).** `tach_in` toggling every cycle → `edge_count`=15. Then an edge gap of exactly 14 cycles → `period`=14. A gap of ≥16 → `stall`=1 and `period`=0.
6. **Reset mid-operation.** Run scenario 1 and assert `rst` for 1 cycle at `win`=9 → all outputs 0 on the next cycle. The next `count_valid` comes 20 cycles after release, and the first post-reset rise only arms.
